// File: rtl/ro_pair_sequencer.sv
// RO-PUF pair sequencer: steps a shared toggle counter across RO pairs
// and assembles the response, tie and timeout flags.
module ro_pair_sequencer #(
    parameter int N_PAIRS       = 16,
    parameter int SEL_W         = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT_SLACK = 16
) (
    input  logic               clk_ref,
    input  logic               rst,
    input  logic               req,
    input  logic [31:0]        window_cycles,
    output logic [SEL_W-1:0]   ro_sel,
    output logic               ro_en,
    output logic               ctr_start,
    output logic [31:0]        ctr_window,
    input  logic [31:0]        ctr_count,
    input  logic               ctr_done,
    output logic               busy,
    output logic [N_PAIRS-1:0] response,
    output logic [N_PAIRS-1:0] tie,
    output logic               err,
    output logic               valid
);

    localparam int PW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t         state;
    state_t         next;
    logic [PW-1:0]  pair;
    logic           phase;
    logic [SW-1:0]  settle;
    logic [32:0]    tmo;
    logic [32:0]    tmo_inc;
    logic [32:0]    thr;
    logic [31:0]    cnt_a;
    logic [31:0]    cnt_b;
    logic           settle_last;
    logic           last_pair;
    logic           timeout;
    logic           active;

    assign settle_last = (settle == SW'(SETTLE_CYCLES - 1));
    assign last_pair   = (pair == PW'(N_PAIRS - 1));
    // 33-bit threshold so a window near 2^32-1 cannot wrap to a tiny limit
    assign thr         = {1'b0, ctr_window} + 33'(TIMEOUT_SLACK);
    assign tmo_inc     = tmo + 33'd1;
    assign timeout     = (tmo_inc > thr);

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   if (req) next = S_SELECT;
            S_SELECT: if (settle_last) next = S_START;
            S_START:  next = S_WAIT;
            S_WAIT: begin
                if (ctr_done)     next = S_STORE;
                else if (timeout) next = S_DONE;
            end
            S_STORE:  next = (phase && last_pair) ? S_DONE : S_SELECT;
            S_DONE:   next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_comb begin
        active    = (state == S_SELECT) || (state == S_START) ||
                    (state == S_WAIT)   || (state == S_STORE);
        ro_en     = active;
        busy      = active;
        ctr_start = (state == S_START);
        ro_sel    = active ? SEL_W'({pair, phase}) : '0;
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state      <= S_IDLE;
            pair       <= '0;
            phase      <= 1'b0;
            settle     <= '0;
            tmo        <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            ctr_window <= '0;
            response   <= '0;
            tie        <= '0;
            err        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state <= next;
            // timer reads 0 during START and counts edges since the pulse
            tmo   <= ((state == S_START) || (state == S_WAIT)) ? tmo_inc : '0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        ctr_window <= window_cycles;
                        pair       <= '0;
                        phase      <= 1'b0;
                        settle     <= '0;
                        response   <= '0;
                        tie        <= '0;
                        err        <= 1'b0;
                        valid      <= 1'b0;
                    end
                end
                S_SELECT: settle <= settle_last ? '0 : settle + SW'(1);
                S_WAIT: begin
                    if (ctr_done) begin
                        if (phase) cnt_b <= ctr_count;
                        else       cnt_a <= ctr_count;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        valid <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        response[pair] <= (cnt_a > cnt_b);
                        tie[pair]      <= (cnt_a == cnt_b);
                        if (last_pair) begin
                            valid <= 1'b1;
                        end else begin
                            pair  <= pair + PW'(1);
                            phase <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
